// File: rtl/digota_pkg.sv
// digota_pkg: state encoding and trim-code constants shared by the OTA offset calibrator.
package digota_pkg;
    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DECIDE, FINISH, TRACK} state_t;
    localparam int TRACK_PERIOD = 256;
    function automatic int trim_mid(input int w);
        return 1 << (w - 1);
    endfunction
    function automatic int trim_max(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/digota_sample_acc.sv
// digota_sample_acc: counts NAVG OTA samples and votes them into high/low/balanced flags.
// The low-side vote port only exists when DIGOTA_CAL_TRACK_EN is defined.
module digota_sample_acc
    import digota_pkg::*;
#(
    parameter int NAVG = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_ota_out,
    input  logic i_ota_en,
    output logic o_win_hi,
    output logic o_balanced,
    output logic o_sample_done
`ifdef DIGOTA_CAL_TRACK_EN
    ,
    output logic o_win_lo
`endif
);
    localparam int CW = $clog2(NAVG + 1);
    logic [CW-1:0] r_cnt, r_ones, r_bal;
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt  <= '0;
            r_ones <= '0;
            r_bal  <= '0;
        end else if (i_en) begin
            r_cnt  <= r_cnt + 1'b1;
            r_ones <= r_ones + CW'(i_ota_en & i_ota_out);
            r_bal  <= r_bal + CW'(!i_ota_en);
        end
    end
    // The last sample lands on the same edge the FSM leaves SAMPLE, so the flags are final in DECIDE.
    assign o_sample_done = i_en && (r_cnt == CW'(NAVG - 1));
    assign o_win_hi      = r_ones > CW'(NAVG / 2);
    assign o_balanced    = r_bal == CW'(NAVG);
`ifdef DIGOTA_CAL_TRACK_EN
    assign o_win_lo      = r_ones < CW'(NAVG / 2);
`endif
endmodule

// File: rtl/digota_cal_ctrl.sv
// digota_cal_ctrl: SAR offset-trim sequencer for the digital OTA comparator cell.
// Define DIGOTA_CAL_TRACK_EN to add periodic +/-1 background tracking after calibration.
module digota_cal_ctrl
    import digota_pkg::*;
#(
    parameter int TRIM_W     = 5,
    parameter int SETTLE_CYC = 8,
    parameter int NAVG       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ota_out,
    input  logic              ota_en,
    output logic              cal_short,
    output logic [TRIM_W-1:0] trim_code,
    output logic              busy,
    output logic              done,
    output logic              cal_err
);
    localparam int BW = $clog2(TRIM_W);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [TRIM_W-1:0] MID = TRIM_W'(trim_mid(TRIM_W));
    localparam logic [TRIM_W-1:0] MAX = TRIM_W'(trim_max(TRIM_W));

    state_t            r_state;
    logic [BW-1:0]     r_bit;
    logic [SW-1:0]     r_settle;
    logic [TRIM_W-1:0] r_trim;
    logic              r_cal_short, r_busy, r_done, r_cal_err;
    logic              w_win_hi, w_balanced, w_sample_done;
`ifdef DIGOTA_CAL_TRACK_EN
    logic                            w_win_lo, r_trk;
    logic [$clog2(TRACK_PERIOD)-1:0] r_tcnt;
    logic [TRIM_W-1:0]               w_trk_trim;
    always_comb begin
        w_trk_trim = (w_win_hi && r_trim != '0) ? r_trim - 1'b1 :
                     (w_win_lo && !w_balanced && r_trim != MAX) ? r_trim + 1'b1 : r_trim;
    end
`endif

    digota_sample_acc #(.NAVG(NAVG)) u_acc (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (r_state == SETTLE),
        .i_en         (r_state == SAMPLE),
        .i_ota_out    (ota_out),
        .i_ota_en     (ota_en),
        .o_win_hi     (w_win_hi),
        .o_balanced   (w_balanced),
        .o_sample_done(w_sample_done)
`ifdef DIGOTA_CAL_TRACK_EN
        ,
        .o_win_lo     (w_win_lo)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit       <= '0;
            r_settle    <= '0;
            r_trim      <= MID;
            r_cal_short <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cal_err   <= 1'b0;
`ifdef DIGOTA_CAL_TRACK_EN
            r_trk       <= 1'b0;
            r_tcnt      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, TRACK: begin
                    if (start) begin
                        r_state     <= SETTLE;
                        r_bit       <= BW'(TRIM_W - 1);
                        r_settle    <= '0;
                        r_trim      <= MID;
                        r_cal_short <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cal_err   <= 1'b0;
`ifdef DIGOTA_CAL_TRACK_EN
                        r_trk       <= 1'b0;
                    end else if (r_state == TRACK) begin
                        r_tcnt <= r_tcnt + 1'b1;
                        if (r_tcnt == '1) begin
                            r_state     <= SETTLE;
                            r_settle    <= '0;
                            r_cal_short <= 1'b1;
                            r_trk       <= 1'b1;
                        end
`endif
                    end
                end
                SETTLE: begin
                    r_settle <= r_settle + 1'b1;
                    if (r_settle == SW'(SETTLE_CYC - 1)) r_state <= SAMPLE;
                end
                SAMPLE: begin
                    if (w_sample_done) begin
                        r_state <= DECIDE;
`ifdef DIGOTA_CAL_TRACK_EN
                        if (r_trk) r_cal_short <= 1'b0;
`endif
                    end
                end
                DECIDE: begin
`ifdef DIGOTA_CAL_TRACK_EN
                    if (r_trk) begin
                        r_trim    <= w_trk_trim;
                        r_cal_err <= (w_trk_trim == '0) || (w_trk_trim == MAX);
                        r_trk     <= 1'b0;
                        r_tcnt    <= '0;
                        r_state   <= TRACK;
                    end else
`endif
                    begin
                        // A fully balanced window means this code is the answer; stop searching.
                        if (w_balanced) r_state <= FINISH;
                        else begin
                            if (w_win_hi) r_trim[r_bit] <= 1'b0;
                            if (r_bit == '0) r_state <= FINISH;
                            else begin
                                r_bit                <= r_bit - 1'b1;
                                r_trim[r_bit - 1'b1] <= 1'b1;
                                r_settle             <= '0;
                                r_state              <= SETTLE;
                            end
                        end
                    end
                end
                FINISH: begin
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_cal_short <= 1'b0;
                    r_cal_err   <= (r_trim == '0) || (r_trim == MAX);
`ifdef DIGOTA_CAL_TRACK_EN
                    r_tcnt      <= '0;
                    r_state     <= TRACK;
`else
                    r_state     <= IDLE;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cal_short = r_cal_short;
    assign trim_code = r_trim;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cal_err   = r_cal_err;
endmodule

// File: tb/tb_digota_cal_ctrl.sv
// tb_digota_cal_ctrl: table-driven calibration runs against a threshold OTA model with a done scoreboard.
module tb_digota_cal_ctrl;
    typedef struct {
        int k;
        int mode;
        int trim;
        int lat;
        int err;
        bit poke;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, start, ota_out, ota_en, cal_short, busy, done, cal_err;
    logic [4:0] trim_code;
    logic       tog = 1'b0;
    int         kk, md, cyc, t0, ndone;
    int         errs, checks;
    vec_t       tbl[8];
    vec_t       q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) tog <= ~tog;

    // mode 0: threshold at kk; mode 1: stuck high; mode 2: output toggles every cycle
    always_comb begin
        ota_out = (md == 0) ? (int'(trim_code) > kk) : (md == 1) ? 1'b1 : tog;
        ota_en  = (md == 0) ? (int'(trim_code) != kk) : 1'b1;
    end

    digota_cal_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ota_out  (ota_out),
        .ota_en   (ota_en),
        .cal_short(cal_short),
        .trim_code(trim_code),
        .busy     (busy),
        .done     (done),
        .cal_err  (cal_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        vec_t e;
        if (rst_n && done) begin
            ndone++;
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = q.pop_front();
                chk("final_trim", int'(trim_code), e.trim);
                chk("latency", cyc - t0, e.lat);
                chk("cal_err", int'(cal_err), e.err);
            end
        end
    end

    task automatic kick();
        @(negedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        chk("accept_busy", int'(busy), 1);
        chk("accept_short", int'(cal_short), 1);
        chk("accept_trim", int'(trim_code), 16);
    endtask

    task automatic run_cal(input vec_t v);
        int  n0;
        bit  got;
        kk = v.k;
        md = v.mode;
        n0 = ndone;
        got = 1'b0;
        kick();
        q.push_back(v);
        for (int i = 1; i <= 200 && !got; i++) begin
            @(negedge clk); #1;
            start = v.poke && (i == 10 || i == 40 || i == 66);
            got = ndone != n0;
        end
        start = 1'b0;
        chk("done_seen", int'(got), 1);
        @(negedge clk); #1;
        chk("post_short", int'(cal_short), 0);
        chk("post_busy", int'(busy), 0);
        chk("post_done", int'(done), 0);
        md = 1;
        repeat (5) @(negedge clk);
        #1;
        chk("hold_trim", int'(trim_code), v.trim);
        chk("done_count", ndone - n0, 1);
    endtask

    initial begin
        int n0;
        bit got;
        tbl[0] = '{20, 0, 20, 40, 0, 1'b0};
        tbl[1] = '{31, 0, 31, 66, 1, 1'b0};
        tbl[2] = '{0, 1, 0, 66, 1, 1'b0};
        tbl[3] = '{0, 2, 31, 66, 1, 1'b1};
        tbl[4] = '{7, 0, 7, 66, 0, 1'b0};
        tbl[5] = '{0, 0, 0, 66, 1, 1'b0};
        tbl[6] = '{16, 0, 16, 14, 0, 1'b0};
        tbl[7] = '{24, 0, 24, 27, 0, 1'b0};
        rst_n = 1'b0;
        start = 1'b0;
        kk = 0;
        md = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_trim", int'(trim_code), 16);
        chk("rst_busy", int'(busy), 0);
        chk("rst_short", int'(cal_short), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(cal_err), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) run_cal(tbl[i]);

        // abort a run with a one-cycle reset at cycle 20
        kk = 31;
        md = 0;
        n0 = ndone;
        kick();
        q.push_back(tbl[1]);
        repeat (20) @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        q.delete();
        chk("abort_busy", int'(busy), 0);
        chk("abort_short", int'(cal_short), 0);
        chk("abort_trim", int'(trim_code), 16);
        chk("abort_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("abort_no_done", ndone - n0, 0);
        run_cal(tbl[0]);

`ifdef DIGOTA_CAL_TRACK_EN
        run_cal(tbl[0]);
        md = 0;
        kk = 22;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = trim_code != 5'd20;
        end
        chk("track_step1", int'(trim_code), 21);
        chk("track_busy", int'(busy), 0);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = trim_code != 5'd21;
        end
        chk("track_step2", int'(trim_code), 22);
        repeat (600) @(negedge clk);
        chk("track_hold", int'(trim_code), 22);
        chk("track_err", int'(cal_err), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
